// File: rtl/display_scanner.sv
// display_scanner: multiplexes four BCD digits onto a 4-digit 7-segment display,
// with per-scan shadowing, a colon dp on digit 2 and blinking of the digit under adjustment.
module display_scanner #(
    parameter int DIV = 4
) (
    input  logic       refreshClock,
    input  logic       reset,
    input  logic [2:0] counter3,
    input  logic [3:0] counter2,
    input  logic [2:0] counter1,
    input  logic [3:0] counter0,
    input  logic [1:0] select,
    input  logic       isAdj,
    input  logic       twoHz,
    output logic [3:0] an,
    output logic [7:0] seg
);
    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] presc;
    logic [1:0]  idx;
    logic [2:0]  sh3, sh1;
    logic [3:0]  sh2, sh0;
    logic [2:0]  sync;
    logic        blink_phase;
    logic        rise;
    logic [3:0]  digit;
    logic        in_range;
    logic [6:0]  dec;

    // sync[1] is the synchronized twoHz, sync[2] its previous value
    assign rise = sync[1] & ~sync[2];

    always_comb begin
        digit = idx == 2'd3 ? {1'b0, sh3} : idx == 2'd2 ? sh2 : idx == 2'd1 ? {1'b0, sh1} : sh0;
        in_range = idx[0] ? digit <= 4'd5 : digit <= 4'd9;
        case (digit)
            4'd0:    dec = 7'h40;
            4'd1:    dec = 7'h79;
            4'd2:    dec = 7'h24;
            4'd3:    dec = 7'h30;
            4'd4:    dec = 7'h19;
            4'd5:    dec = 7'h12;
            4'd6:    dec = 7'h02;
            4'd7:    dec = 7'h78;
            4'd8:    dec = 7'h00;
            4'd9:    dec = 7'h10;
            default: dec = 7'h3F;
        endcase
        if (!in_range) dec = 7'h3F;
    end

    always_ff @(posedge refreshClock) begin
        if (reset) begin
            presc       <= '0;
            idx         <= '0;
            sh3         <= '0;
            sh2         <= '0;
            sh1         <= '0;
            sh0         <= '0;
            sync        <= '0;
            blink_phase <= 1'b0;
            an          <= 4'hF;
            seg         <= 8'hFF;
        end else begin
            presc <= presc == LAST ? 16'd0 : presc + 16'd1;
            if (presc == LAST) begin
                idx <= idx + 2'd1;
                // shadows reload only at the end of a full scan so a scan never tears
                if (idx == 2'd3) begin
                    sh3 <= counter3;
                    sh2 <= counter2;
                    sh1 <= counter1;
                    sh0 <= counter0;
                end
            end
            sync        <= {sync[1:0], twoHz};
            blink_phase <= isAdj & (blink_phase ^ rise);
            an          <= (isAdj && blink_phase && idx == select) ? 4'hF : ~(4'b0001 << idx);
            seg         <= {idx != 2'd2, dec};
        end
    end
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: directed stimulus with a cycle-stamped scoreboard queue
// checked by an independent monitor on the falling clock edge.
module tb_display_scanner;
    localparam int B = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] counter3 = 3'd1;
    logic [3:0] counter2 = 4'd2;
    logic [2:0] counter1 = 3'd3;
    logic [3:0] counter0 = 4'd4;
    logic [1:0] select = 2'd0;
    logic       isAdj = 1'b0;
    logic       twoHz = 1'b0;
    logic [3:0] an;
    logic [7:0] seg;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [7:0] seg;
        string      name;
    } exp_t;
    exp_t sb[$];

    display_scanner #(.DIV(4)) dut (
        .refreshClock(clk),
        .reset(reset),
        .counter3(counter3),
        .counter2(counter2),
        .counter1(counter1),
        .counter0(counter0),
        .select(select),
        .isAdj(isAdj),
        .twoHz(twoHz),
        .an(an),
        .seg(seg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [3:0] a, input logic [7:0] s, input string nm);
        exp_t e;
        e.cyc = c;
        e.an = a;
        e.seg = s;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitor: compare every expectation due at or before this cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
            end else if (an !== e.an || seg !== e.seg) begin
                n_fail++;
                $display("FAIL %s @%0d: an=%b seg=%h, required an=%b seg=%h",
                         e.name, cyc, an, seg, e.an, e.seg);
            end
        end
    end

    initial begin
        push(1, 4'hF, 8'hFF, "reset_1");
        push(2, 4'hF, 8'hFF, "reset_2");
        push(3, 4'hF, 8'hFF, "reset_3");
        push(B + 1, 4'hE, 8'hC0, "first_after_release");
        push(B + 4, 4'hE, 8'hC0, "scan0_hold");
        push(B + 5, 4'hD, 8'hC0, "scan1");
        push(B + 9, 4'hB, 8'h40, "scan2_dp");
        push(B + 13, 4'h7, 8'hC0, "scan3");
        push(B + 16, 4'h7, 8'hC0, "scan3_before_load");
        push(B + 17, 4'hE, 8'h99, "decode_d0");
        push(B + 21, 4'hD, 8'hB0, "decode_d1");
        push(B + 25, 4'hB, 8'h24, "decode_d2");
        at(B);
        reset = 1'b0;

        at(B + 26);
        counter0 = 4'd7;
        counter3 = 3'd5;
        push(B + 29, 4'h7, 8'hF9, "shadow_no_tear_d3");
        push(B + 33, 4'hE, 8'hF8, "shadow_new_d0");

        at(B + 34);
        counter1 = 3'd6;
        counter2 = 4'hA;
        push(B + 45, 4'h7, 8'h92, "shadow_new_d3");
        push(B + 49, 4'hE, 8'hF8, "range_d0");
        push(B + 53, 4'hD, 8'hBF, "range_d1_dash");
        push(B + 57, 4'hB, 8'h3F, "range_d2_dash_dp");
        push(B + 61, 4'h7, 8'h92, "range_d3");

        at(B + 64);
        isAdj = 1'b1;
        select = 2'd1;
        push(B + 69, 4'hD, 8'hBF, "blink_before_edge");
        push(B + 70, 4'hF, 8'hBF, "blink_blanked");
        push(B + 72, 4'hF, 8'hBF, "blink_blanked_hold");
        push(B + 73, 4'hB, 8'h3F, "blink_other_digit");
        at(B + 66);
        twoHz = 1'b1;
        at(B + 74);
        twoHz = 1'b0;
        at(B + 83);
        twoHz = 1'b1;
        push(B + 85, 4'hF, 8'hBF, "blink_still_blanked");
        push(B + 86, 4'hF, 8'hBF, "blink_before_restore");
        push(B + 87, 4'hD, 8'hBF, "blink_restored");
        push(B + 88, 4'hD, 8'hBF, "blink_restored_hold");
        at(B + 88);
        twoHz = 1'b0;
        at(B + 90);
        twoHz = 1'b1;
        at(B + 94);
        select = 2'd3;
        push(B + 95, 4'hF, 8'h92, "select_change_blanks_d3");
        at(B + 95);
        isAdj = 1'b0;
        select = 2'd0;
        push(B + 96, 4'h7, 8'h92, "adj_off_unblanked");
        at(B + 96);
        isAdj = 1'b1;
        push(B + 97, 4'hE, 8'hF8, "adj_off_cleared_phase");

        at(B + 97);
        twoHz = 1'b0;
        at(B + 100);
        twoHz = 1'b1;
        at(B + 105);
        reset = 1'b1;
        twoHz = 1'b0;
        push(B + 106, 4'hF, 8'hFF, "midscan_reset");
        push(B + 107, 4'hF, 8'hFF, "midscan_reset_hold");
        push(B + 108, 4'hE, 8'hC0, "restart_d0");
        push(B + 112, 4'hD, 8'hC0, "restart_d1");
        at(B + 107);
        reset = 1'b0;

        at(B + 114);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: never checked, required an=%b seg=%h", e.name, e.an, e.seg);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 The module SHALL have parameter DIV, default 4 (legal range 1..65535): refreshClock cycles per digit slot.
REQ-002 The module SHALL have port refreshClock, input, 1 bit: the clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port counter3, input, 3 bits: minutes-tens BCD digit, legal 0..5.
REQ-005 The module SHALL have port counter2, input, 4 bits: minutes-ones BCD digit, legal 0..9.
REQ-006 The module SHALL have port counter1, input, 3 bits: seconds-tens BCD digit, legal 0..5.
REQ-007 The module SHALL have port counter0, input, 4 bits: seconds-ones BCD digit, legal 0..9.
REQ-008 The module SHALL have port select, input, 2 bits: digit under adjustment (0=counter0 .. 3=counter3).
REQ-009 The module SHALL have port isAdj, input, 1 bit: adjust mode, which enables blinking.
REQ-010 The module SHALL have port twoHz, input, 1 bit: asynchronous blink-rate square wave.
REQ-011 The module SHALL have port an, output, 4 bits: active-low anode enables; an[i] drives digit i, an[0] is the rightmost digit.
REQ-012 The module SHALL have port seg, output, 8 bits: active-low segments {dp,g,f,e,d,c,b,a}.

Function
REQ-013 The prescaler SHALL count 0..DIV-1; at DIV-1 it SHALL return to 0 and the digit index (2 bits) SHALL advance by 1, wrapping 3->0.
REQ-014 On the same cycle the index wraps 3->0, shadow registers SHALL load counter3..counter0; the displayed digits SHALL come only from the shadow registers, so there is no tearing within a scan.
REQ-015 twoHz SHALL pass through a 2-flop synchronizer and then a rising-edge detector; each detected rising edge SHALL toggle blinkPhase.
REQ-016 blinkPhase SHALL be held at 0 on every cycle where isAdj=0.
REQ-017 an and seg SHALL be registered, reflecting the index, shadow, blinkPhase, select and isAdj values of the previous cycle (1-cycle latency).
REQ-018 an SHALL be one-hot-low at bit index, except that it SHALL be 4'b1111 when isAdj=1, blinkPhase=1 and index==select (selected digit blanked).
REQ-019 seg[6:0] SHALL decode the shadow digit at the current index as follows: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, bit7 shown as 1).
REQ-020 An out-of-range digit (counter3/counter1 value >5, or counter2/counter0 value >9) SHALL display a dash, seg=0xBF.
REQ-021 seg[7] (dp) SHALL be 0 only when index==2, marking the minutes:seconds separator; otherwise it SHALL be 1.
REQ-022 While a digit is blanked, seg SHALL still carry its decode; only an is forced high.
REQ-023 A select change mid-scan SHALL take effect on the next registered output, because select is not shadowed.

Reset
REQ-024 While reset=1 at a clock edge, the following SHALL hold: prescaler=0, index=0, all shadows=0, blinkPhase=0, synchronizer and edge-detector flops=0, an=4'b1111, seg=8'hFF.
REQ-025 Reset SHALL override all other activity, including mid-scan and mid-blink.
REQ-026 On the first cycle after reset release, outputs SHALL show index 0 of the zero shadow: an=1110, seg=C0.
REQ-027 The first shadow load after reset SHALL occur at the first 3->0 wrap, 4*DIV cycles after release.

Verification
REQ-028 Scan test: DIV=4, reset released -> an sequence 1110, 1101, 1011, 0111, each held 4 cycles, then repeats.
REQ-029 Decode test: counters 3,2,1,0 = 1,2,3,4, after one shadow load -> an=1110/seg=99, an=1101/seg=B0, an=1011/seg=24, an=0111/seg=F9.
REQ-030 Shadow test: counter0 changes 4->7 while index=2 -> digit 0 shows 99 until after the next wrap, then shows F8.
REQ-031 Blink test: isAdj=1, select=1, rising edge on twoHz -> about 3 cycles later blinkPhase=1 and the index-1 slot shows an=1111; the next twoHz rising edge restores an=1101; dropping isAdj clears blinkPhase the next cycle.
REQ-032 Range test: counter1=6 and counter2=4'hA -> those slots show seg=BF, with the index-2 slot showing seg=3F because dp is lit.
REQ-033 Reset test: assert reset while index=2 and blinkPhase=1 -> next edge gives an=1111, seg=FF; after release the scan restarts at index 0.
